fft_r22sdf_bf: RTL and testbench

FFT_R22SDF_BF -- requirements
Module: fft_r22sdf_bf

---
 rtl/fft_r22sdf_pkg.sv | 21 ++
 rtl/fft_r22sdf_bf_if.sv | 23 ++
 rtl/fft_r22sdf_sr.sv | 39 +++
 rtl/fft_r22sdf_bf.sv | 119 +++++++++++
 tb/tb_fft_r22sdf_bf.sv | 130 +++++++++++++
 5 files changed

// File: rtl/fft_r22sdf_pkg.sv
// rtl/fft_r22sdf_pkg.sv - shared constants and helpers for the R2^2 SDF FFT stages
package fft_r22sdf_pkg;

  localparam int MODE_BFI  = 0;
  localparam int MODE_BFII = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Halve with round-half-up; callers truncate the result to their output width.
  function automatic logic signed [63:0] round_halve(input logic signed [63:0] s);
    return (s + 64'sd1) >>> 1;
  endfunction

endpackage

// File: rtl/fft_r22sdf_bf_if.sv
// rtl/fft_r22sdf_bf_if.sv - sample stream bundle into and out of one butterfly stage
interface fft_r22sdf_bf_if #(
  parameter int DW = 25,
  parameter int OW = 26
);
  logic                 valid_i;
  logic                 sync_i;
  logic signed [DW-1:0] x_re_i;
  logic signed [DW-1:0] x_im_i;
  logic                 valid_o;
  logic signed [OW-1:0] z_re_o;
  logic signed [OW-1:0] z_im_o;

  modport master (
    output valid_i, sync_i, x_re_i, x_im_i,
    input  valid_o, z_re_o, z_im_o
  );

  modport slave (
    input  valid_i, sync_i, x_re_i, x_im_i,
    output valid_o, z_re_o, z_im_o
  );
endinterface

// File: rtl/fft_r22sdf_sr.sv
// rtl/fft_r22sdf_sr.sv - enable-gated feedback delay line; q_o is the oldest word
module fft_r22sdf_sr #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Index 0 is the oldest word; new data enters at the top.
  always_comb begin
    mem_d = mem_q;
    if (en_i) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
      mem_d[DEPTH-1] = d_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign q_o = mem_q[0];

endmodule

// File: rtl/fft_r22sdf_bf.sv
// rtl/fft_r22sdf_bf.sv - radix-2^2 single-path delay feedback butterfly stage (BF-I / BF-II)
module fft_r22sdf_bf
  import fft_r22sdf_pkg::*;
#(
  parameter int DW    = 25,
  parameter int DEPTH = 16,
  parameter int MODE  = 0,
  parameter int SCALE = 0
) (
  input  logic           clk_i,
  input  logic           rst_n,
  fft_r22sdf_bf_if.slave bus
);

  localparam int OW = (SCALE != 0) ? DW : DW + 1;
  localparam int SW = OW + 1;
  localparam int LD = clog2(DEPTH);
  localparam int CW = (MODE == MODE_BFII) ? LD + 2 : LD + 1;
  localparam int PW = LD + 1;

  logic [CW-1:0]        cnt_q, cnt_d, cnt_cur;
  logic [PW-1:0]        pcnt_q, pcnt_d, pcnt_cur;
  logic                 valid_o_q, valid_o_d;
  logic signed [OW-1:0] z_re_q, z_re_d, z_im_q, z_im_d;

  logic                 sel, rot, primed;
  logic signed [DW-1:0] neg_re, a_re, a_im;
  logic signed [OW-1:0] xe_re, xe_im, xsr_re, xsr_im;
  logic signed [OW-1:0] sr_in_re, sr_in_im, out_re, out_im;
  logic signed [SW-1:0] sum_re, sum_im, dif_re, dif_im;

  function automatic logic signed [OW-1:0] fsc(input logic signed [SW-1:0] s);
    if (SCALE != 0) return OW'(round_halve(64'(s)));
    return OW'(s);
  endfunction

  always_comb begin
    cnt_cur  = bus.sync_i ? '0 : cnt_q;
    pcnt_cur = bus.sync_i ? '0 : pcnt_q;
    sel      = cnt_cur[LD];
    // For BF-I the top counter bit is sel itself, so rot is forced off by MODE.
    rot      = (MODE == MODE_BFII) && sel && cnt_cur[CW-1];
    primed   = (pcnt_cur == PW'(DEPTH));

    // -x_re of the most negative code has no positive twin; clamp it.
    neg_re = (bus.x_re_i == {1'b1, {(DW-1){1'b0}}}) ? {1'b0, {(DW-1){1'b1}}} : -bus.x_re_i;
    a_re   = rot ? bus.x_im_i : bus.x_re_i;
    a_im   = rot ? neg_re     : bus.x_im_i;
    xe_re  = OW'(a_re);
    xe_im  = OW'(a_im);

    sum_re = SW'(xe_re) + SW'(xsr_re);
    sum_im = SW'(xe_im) + SW'(xsr_im);
    dif_re = SW'(xsr_re) - SW'(xe_re);
    dif_im = SW'(xsr_im) - SW'(xe_im);

    if (sel) begin
      out_re   = fsc(sum_re);
      out_im   = fsc(sum_im);
      sr_in_re = fsc(dif_re);
      sr_in_im = fsc(dif_im);
    end else begin
      out_re   = xsr_re;
      out_im   = xsr_im;
      sr_in_re = xe_re;
      sr_in_im = xe_im;
    end

    cnt_d     = cnt_q;
    pcnt_d    = pcnt_q;
    z_re_d    = z_re_q;
    z_im_d    = z_im_q;
    valid_o_d = 1'b0;
    if (bus.valid_i) begin
      cnt_d     = cnt_cur + CW'(1);
      pcnt_d    = primed ? pcnt_cur : pcnt_cur + PW'(1);
      z_re_d    = out_re;
      z_im_d    = out_im;
      valid_o_d = primed;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      pcnt_q    <= '0;
      z_re_q    <= '0;
      z_im_q    <= '0;
      valid_o_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pcnt_q    <= pcnt_d;
      z_re_q    <= z_re_d;
      z_im_q    <= z_im_d;
      valid_o_q <= valid_o_d;
    end
  end

  fft_r22sdf_sr #(.WIDTH(OW), .DEPTH(DEPTH)) u_sr_re (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .en_i  (bus.valid_i),
    .d_i   (sr_in_re),
    .q_o   (xsr_re)
  );

  fft_r22sdf_sr #(.WIDTH(OW), .DEPTH(DEPTH)) u_sr_im (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .en_i  (bus.valid_i),
    .d_i   (sr_in_im),
    .q_o   (xsr_im)
  );

  assign bus.valid_o = valid_o_q;
  assign bus.z_re_o  = z_re_q;
  assign bus.z_im_o  = z_im_q;

endmodule

// File: tb/tb_fft_r22sdf_bf.sv
// tb/tb_fft_r22sdf_bf.sv - table-driven bench for fft_r22sdf_bf in three configurations
module tb_fft_r22sdf_bf;

  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_i = ~clk_i;

  fft_r22sdf_bf_if #(.DW(8), .OW(9)) ia ();
  fft_r22sdf_bf_if #(.DW(8), .OW(8)) ib ();
  fft_r22sdf_bf_if #(.DW(8), .OW(9)) ic ();

  fft_r22sdf_bf #(.DW(8), .DEPTH(4), .MODE(0), .SCALE(0)) u_a (.clk_i(clk_i), .rst_n(rst_n), .bus(ia));
  fft_r22sdf_bf #(.DW(8), .DEPTH(4), .MODE(0), .SCALE(1)) u_b (.clk_i(clk_i), .rst_n(rst_n), .bus(ib));
  fft_r22sdf_bf #(.DW(8), .DEPTH(2), .MODE(1), .SCALE(0)) u_c (.clk_i(clk_i), .rst_n(rst_n), .bus(ic));

  typedef struct {
    int d;
    bit rst;
    bit vld;
    bit syn;
    int re;
    int im;
    bit ev;
    int ere;
    int eim;
  } vec_t;

  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic add(input int d, input bit rst, input bit vld, input bit syn,
                     input int re, input int im, input bit ev, input int ere, input int eim);
    vec_t v;
    v.d = d; v.rst = rst; v.vld = vld; v.syn = syn; v.re = re; v.im = im;
    v.ev = ev; v.ere = ere; v.eim = eim;
    tbl.push_back(v);
  endtask

  task automatic check(input int row, input string what, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL row %0d %s got %0d expected %0d", row, what, got, exp);
    end
  endtask

  initial begin
    vec_t v;
    int   gv, gre, gim;

    // DUT A: continuous frames with wrap, sync ignored under reset
    add(0, 1, 1, 1, 50, 7, 0, 0, 0);
    for (int k = 1; k <= 8; k++) add(0, 0, 1, k == 1, k, 0, k > 4, (k > 4) ? 2*k - 4 : 0, 0);
    for (int k = 1; k <= 8; k++) add(0, 0, 1, 0, k, 0, 1, (k > 4) ? 2*k - 4 : -4, 0);
    // DUT A: three-cycle valid gap mid-frame
    add(0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      add(0, 0, 1, k == 1, k, 0, k > 4, (k > 4) ? 2*k - 4 : 0, 0);
      if (k == 6) for (int g = 0; g < 3; g++) add(0, 0, 0, 0, 99, 99, 0, 8, 0);
    end
    for (int k = 1; k <= 4; k++) add(0, 0, 1, 0, k, 0, 1, -4, 0);
    // DUT A: reset at cnt=5 clears everything in flight
    add(0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) add(0, 0, 1, k == 1, k, 0, k > 4, (k > 4) ? 6 : 0, 0);
    add(0, 1, 1, 1, 77, 77, 0, 0, 0);
    for (int k = 1; k <= 8; k++) add(0, 0, 1, 0, k, 0, k > 4, (k > 4) ? 2*k - 4 : 0, 0);
    // DUT A: sync at cnt=3 restarts the frame and re-primes
    for (int k = 1; k <= 3; k++) add(0, 0, 1, 0, k, 0, 1, -4, 0);
    add(0, 0, 1, 1, 10, 0, 0, -4, 0);
    add(0, 0, 1, 0, 20, 0, 0, 1, 0);
    add(0, 0, 1, 0, 30, 0, 0, 2, 0);
    add(0, 0, 1, 0, 40, 0, 0, 3, 0);
    add(0, 0, 1, 0, 50, 0, 1, 60, 0);
    add(0, 0, 1, 0, 60, 0, 1, 80, 0);
    add(0, 0, 1, 0, 70, 0, 1, 100, 0);
    add(0, 0, 1, 0, 80, 0, 1, 120, 0);

    // DUT B: scaled output at the extremes and round-half-up
    add(1, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) add(1, 0, 1, k == 0, 127, 0, k >= 4, (k >= 4) ? 127 : 0, 0);
    for (int k = 0; k < 4; k++) add(1, 0, 1, 0, -128, 0, 1, 0, 0);
    for (int k = 0; k < 4; k++) add(1, 0, 1, 0, -128, 0, 1, -128, 0);
    for (int k = 0; k < 4; k++) add(1, 0, 1, 0, 3, -3, 1, 0, 0);
    for (int k = 0; k < 4; k++) add(1, 0, 1, 0, 1, 1, 1, 2, -1);
    for (int k = 0; k < 4; k++) add(1, 0, 1, 0, 0, 0, 1, 1, -2);

    // DUT C: BF-II, -j rotation only at cnt 6 and 7, saturating -(-128)
    add(2, 1, 0, 0, 0, 0, 0, 0, 0);
    add(2, 0, 1, 1, 0, 0, 0, 0, 0);
    add(2, 0, 1, 0, 0, 0, 0, 0, 0);
    add(2, 0, 1, 0, -128, 5, 1, -128, 5);
    add(2, 0, 1, 0, 0, 0, 1, 0, 0);
    add(2, 0, 1, 0, 0, 0, 1, 128, -5);
    add(2, 0, 1, 0, 0, 0, 1, 0, 0);
    add(2, 0, 1, 0, -128, 0, 1, 0, 127);
    add(2, 0, 1, 0, 10, 20, 1, 20, -10);
    add(2, 0, 1, 0, 0, 0, 1, 0, -127);
    add(2, 0, 1, 0, 0, 0, 1, -20, 10);

    ia.valid_i = 0; ia.sync_i = 0; ia.x_re_i = 0; ia.x_im_i = 0;
    ib.valid_i = 0; ib.sync_i = 0; ib.x_re_i = 0; ib.x_im_i = 0;
    ic.valid_i = 0; ic.sync_i = 0; ic.x_re_i = 0; ic.x_im_i = 0;

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      rst_n      = !v.rst;
      ia.valid_i = (v.d == 0) && v.vld; ia.sync_i = (v.d == 0) && v.syn;
      ib.valid_i = (v.d == 1) && v.vld; ib.sync_i = (v.d == 1) && v.syn;
      ic.valid_i = (v.d == 2) && v.vld; ic.sync_i = (v.d == 2) && v.syn;
      ia.x_re_i = 8'(v.re); ia.x_im_i = 8'(v.im);
      ib.x_re_i = 8'(v.re); ib.x_im_i = 8'(v.im);
      ic.x_re_i = 8'(v.re); ic.x_im_i = 8'(v.im);
      @(posedge clk_i);
      #1;
      case (v.d)
        0:       begin gv = int'(ia.valid_o); gre = ia.z_re_o; gim = ia.z_im_o; end
        1:       begin gv = int'(ib.valid_o); gre = ib.z_re_o; gim = ib.z_im_o; end
        default: begin gv = int'(ic.valid_o); gre = ic.z_re_o; gim = ic.z_im_o; end
      endcase
      check(i, "valid_o", gv, int'(v.ev));
      check(i, "z_re_o", gre, v.ere);
      check(i, "z_im_o", gim, v.eim);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
